// File: rtl/sprite_cmd_unit.sv
// sprite_cmd_unit: executes sprite commands (ACT, LD, RD, CORD) against a
// per-sprite attribute table. Port A serves commands with a read-modify-write
// sequence. Port B is a registered read-only port for the display engine.
// Entry layout: [31] visible, [30:27] last action, [26:19] image,
//               [18:9] x, [8:0] y.
module sprite_cmd_unit #(
  parameter int ADDR_W      = 8,
  parameter int NUM_SPRITES = 2 ** ADDR_W,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] sprite_addr,
  input  logic [3:0]        sprite_action,
  input  logic              sprite_use_imm,
  input  logic [13:0]       sprite_imm,
  input  logic [31:0]       reg_data,
  input  logic [4:0]        dst_reg,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic [4:0]        rsp_dst_reg,
  output logic              busy,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [31:0]       disp_data
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_RD_WAIT,
    S_MODIFY,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_ACT  = 2'd0;
  localparam logic [1:0] OP_LD   = 2'd1;
  localparam logic [1:0] OP_CORD = 2'd3;

  localparam logic [3:0] ACT_SHOW  = 4'd0;
  localparam logic [3:0] ACT_HIDE  = 4'd1;
  localparam logic [3:0] ACT_SET_X = 4'd2;
  localparam logic [3:0] ACT_SET_Y = 4'd3;
  localparam logic [3:0] ACT_ADD_X = 4'd4;
  localparam logic [3:0] ACT_ADD_Y = 4'd5;

  localparam logic        [9:0]  X_LIM   = 10'(X_MAX);
  localparam logic        [8:0]  Y_LIM   = 9'(Y_MAX);
  localparam logic signed [14:0] X_LIM_S = 15'(X_MAX);
  localparam logic signed [14:0] Y_LIM_S = 15'(Y_MAX);

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0] r_clr_cnt;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_action;
  logic [13:0]       r_opnd;
  logic [4:0]        r_dst;

  logic [31:0] r_mem [NUM_SPRITES];
  logic [31:0] r_rd_data;

  logic              w_accept;
  logic              w_rd_en;
  logic [13:0]       w_opnd;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [31:0]       w_wdata;
  logic [31:0]       w_new_entry;
  logic [31:0]       w_rsp_data;
  logic              w_rsp_load;
  logic signed [14:0] w_sum_x;
  logic signed [14:0] w_sum_y;
  logic [17:0]       w_unused_reg_hi;

  // Only the low 14 bits of the register operand carry meaning.
  assign w_unused_reg_hi = reg_data[31:14];

  assign w_opnd   = sprite_use_imm ? sprite_imm : reg_data[13:0];
  assign w_accept = cmd_valid & cmd_ready;
  // Reserved ops (4-7) are swallowed without touching the RAM.
  assign w_rd_en  = w_accept & ~cmd_op[2];

  // Signed 15-bit sums cannot wrap for a 10-bit coordinate plus a 14-bit operand.
  assign w_sum_x = $signed({5'b0, r_rd_data[18:9]}) + $signed({r_opnd[13], r_opnd});
  assign w_sum_y = $signed({6'b0, r_rd_data[8:0]})  + $signed({r_opnd[13], r_opnd});

  // State register; reset restarts the clear sweep and aborts any command.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_next;
  end

  // Next-state logic, handshake outputs and port-A write selection.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_next    = r_state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    w_we      = 1'b0;
    w_waddr   = r_addr;
    w_wdata   = w_new_entry;
    case (r_state)
      S_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_clr_cnt;
        w_wdata = '0;
        if (&r_clr_cnt) w_next = S_IDLE;
      end
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid && !cmd_op[2]) w_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        w_next = (r_op == OP_ACT || r_op == OP_LD) ? S_MODIFY : S_RESP;
      end
      S_MODIFY: begin
        w_we   = 1'b1;
        w_next = S_IDLE;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_CLEAR;
    endcase
  end

  // Build the updated entry from the value read in RD_WAIT.
  always_comb begin
    w_new_entry = r_rd_data;
    if (r_op == OP_LD) begin
      w_new_entry[26:19] = r_opnd[7:0];
    end else begin
      w_new_entry[30:27] = r_action;
      case (r_action)
        ACT_SHOW:  w_new_entry[31] = 1'b1;
        ACT_HIDE:  w_new_entry[31] = 1'b0;
        ACT_SET_X: w_new_entry[18:9] = (r_opnd[9:0] > X_LIM) ? X_LIM : r_opnd[9:0];
        ACT_SET_Y: w_new_entry[8:0]  = (r_opnd[8:0] > Y_LIM) ? Y_LIM : r_opnd[8:0];
        ACT_ADD_X: begin
          if (w_sum_x[14])             w_new_entry[18:9] = '0;
          else if (w_sum_x > X_LIM_S)  w_new_entry[18:9] = X_LIM;
          else                         w_new_entry[18:9] = w_sum_x[9:0];
        end
        ACT_ADD_Y: begin
          if (w_sum_y[14])             w_new_entry[8:0] = '0;
          else if (w_sum_y > Y_LIM_S)  w_new_entry[8:0] = Y_LIM;
          else                         w_new_entry[8:0] = w_sum_y[8:0];
        end
        default: ;
      endcase
    end
  end

  // Response payload: full entry for RD, packed coordinates for CORD.
  assign w_rsp_data = (r_op == OP_CORD)
                    ? {6'b0, r_rd_data[18:9], 7'b0, r_rd_data[8:0]}
                    : r_rd_data;
  assign w_rsp_load = (r_state == S_RD_WAIT) && (w_next == S_RESP);

  // Clear-sweep counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_clr_cnt <= '0;
    else if (r_state == S_CLEAR)  r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
  end

  // Capture the command fields on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= '0;
      r_addr   <= '0;
      r_action <= '0;
      r_opnd   <= '0;
      r_dst    <= '0;
    end else if (w_accept) begin
      r_op     <= cmd_op[1:0];
      r_addr   <= sprite_addr;
      r_action <= sprite_action;
      r_opnd   <= w_opnd;
      r_dst    <= dst_reg;
    end
  end

  // Port A: synchronous write (clear sweep or MODIFY) and command read.
  // NOTE: the RAM and its read latch carry no reset; the clear sweep initialises contents.
  always_ff @(posedge clk) begin
    if (w_we)    r_mem[w_waddr] <= w_wdata;
    if (w_rd_en) r_rd_data      <= r_mem[sprite_addr];
  end

  // Port B: registered display read; sees old data on a same-cycle port-A write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) disp_data <= '0;
    else     disp_data <= r_mem[disp_addr];
  end

  // One-cycle response pulse; data and destination hold until the next response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_dst_reg <= '0;
    end else begin
      rsp_valid <= w_rsp_load;
      if (w_rsp_load) begin
        rsp_data    <= w_rsp_data;
        rsp_dst_reg <= r_dst;
      end
    end
  end

endmodule

// File: tb/tb_sprite_cmd_unit.sv
// Bench for sprite_cmd_unit: directed commands feed a scoreboard queue that a
// separate monitor drains whenever rsp_valid is seen.
module tb_sprite_cmd_unit;

  localparam logic [2:0] OP_ACT  = 3'd0;
  localparam logic [2:0] OP_LD   = 3'd1;
  localparam logic [2:0] OP_RD   = 3'd2;
  localparam logic [2:0] OP_CORD = 3'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  sprite_addr;
  logic [3:0]  sprite_action;
  logic        sprite_use_imm;
  logic [13:0] sprite_imm;
  logic [31:0] reg_data;
  logic [4:0]  dst_reg;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_dst_reg;
  logic        busy;
  logic [7:0]  disp_addr;
  logic [31:0] disp_data;

  sprite_cmd_unit dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .sprite_addr    (sprite_addr),
    .sprite_action  (sprite_action),
    .sprite_use_imm (sprite_use_imm),
    .sprite_imm     (sprite_imm),
    .reg_data       (reg_data),
    .dst_reg        (dst_reg),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_dst_reg    (rsp_dst_reg),
    .busy           (busy),
    .disp_addr      (disp_addr),
    .disp_data      (disp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dst;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ent(input logic v, input logic [3:0] a,
                                      input logic [7:0] img, input logic [9:0] x,
                                      input logic [8:0] y);
    return {v, a, img, x, y};
  endfunction

  function automatic logic [31:0] cord(input logic [9:0] x, input logic [8:0] y);
    return {6'b0, x, 7'b0, y};
  endfunction

  // Monitor: every response must match the oldest expectation, 2 cycles after its accept.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 data 0x%08h, expected no response", rsp_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_data"}, rsp_data, e.data);
        check({e.name, "_dst"}, 32'(rsp_dst_reg), 32'(e.dst));
        check({e.name, "_latency"}, 32'(cyc - e.acc_cyc), 32'd2);
      end
    end
  end

  // Issue one command once cmd_ready is seen; entered and left at posedge+1.
  task automatic send(input logic [2:0] op, input logic [7:0] addr, input logic [3:0] act,
                      input logic use_imm, input logic [13:0] imm, input logic [31:0] rdata,
                      input logic [4:0] dst, input logic exp_rsp, input logic [31:0] exp_data,
                      input string name);
    int   waited;
    exp_t e;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 1000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_ready_timeout: got cmd_ready=%b, expected 1 within 1000 cycles", name, cmd_ready);
      return;
    end
    cmd_valid      = 1'b1;
    cmd_op         = op;
    sprite_addr    = addr;
    sprite_action  = act;
    sprite_use_imm = use_imm;
    sprite_imm     = imm;
    reg_data       = rdata;
    dst_reg        = dst;
    if (exp_rsp) begin
      e.data    = exp_data;
      e.dst     = dst;
      e.acc_cyc = cyc;
      e.name    = name;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Release reset at a falling edge and measure the clear sweep length.
  task automatic release_and_clear(input string name);
    int n;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (cmd_ready !== 1'b1 && n < 400);
    check({name, "_cycles"}, 32'(n), 32'd256);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic disp_sweep(input string name);
    for (int i = 0; i < 256; i++) begin
      disp_addr = 8'(i);
      @(posedge clk); #1;
      check($sformatf("%s_%0d", name, i), disp_data, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    cmd_valid      = 1'b0;
    cmd_op         = '0;
    sprite_addr    = '0;
    sprite_action  = '0;
    sprite_use_imm = 1'b1;
    sprite_imm     = '0;
    reg_data       = '0;
    dst_reg        = '0;
    disp_addr      = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_dst", 32'(rsp_dst_reg), 32'd0);
    check("rst_disp_data", disp_data, 32'd0);

    release_and_clear("clear1");
    disp_sweep("sweep1");

    // LD then RD of the same sprite.
    send(OP_LD, 8'd5, 4'd0, 1'b1, 14'h02A, 32'd0, 5'd0, 1'b0, 32'd0, "ld5");
    send(OP_RD, 8'd5, 4'd0, 1'b1, 14'h000, 32'd0, 5'd7, 1'b1, ent(1'b0, 4'd0, 8'h2A, 10'd0, 9'd0), "rd5");

    // x saturation and ADD clamping, then y.
    send(OP_ACT,  8'd3, 4'd2, 1'b1, 14'd600,  32'd0, 5'd0, 1'b0, 32'd0, "setx600");
    send(OP_ACT,  8'd3, 4'd4, 1'b1, 14'd100,  32'd0, 5'd0, 1'b0, 32'd0, "addx100");
    send(OP_CORD, 8'd3, 4'd0, 1'b1, 14'd0,    32'd0, 5'd3, 1'b1, cord(10'd639, 9'd0), "cord_xmax");
    send(OP_ACT,  8'd3, 4'd4, 1'b1, 14'h3D44, 32'd0, 5'd0, 1'b0, 32'd0, "addx_m700");
    send(OP_CORD, 8'd3, 4'd0, 1'b1, 14'd0,    32'd0, 5'd4, 1'b1, cord(10'd0, 9'd0), "cord_xzero");
    send(OP_RD,   8'd3, 4'd0, 1'b1, 14'd0,    32'd0, 5'd5, 1'b1, ent(1'b0, 4'd4, 8'h00, 10'd0, 9'd0), "rd3_act4");
    send(OP_ACT,  8'd3, 4'd3, 1'b1, 14'd500,  32'd0, 5'd0, 1'b0, 32'd0, "sety500");
    send(OP_ACT,  8'd3, 4'd5, 1'b1, 14'h3FFB, 32'd0, 5'd0, 1'b0, 32'd0, "addy_m5");
    send(OP_CORD, 8'd3, 4'd0, 1'b1, 14'd0,    32'd0, 5'd6, 1'b1, cord(10'd0, 9'd474), "cord_y474");
    send(OP_ACT,  8'd3, 4'd5, 1'b1, 14'd100,  32'd0, 5'd0, 1'b0, 32'd0, "addy100");
    send(OP_ACT,  8'd3, 4'd2, 1'b1, 14'h0405, 32'd0, 5'd0, 1'b0, 32'd0, "setx_trunc");
    send(OP_CORD, 8'd3, 4'd0, 1'b1, 14'd0,    32'd0, 5'd8, 1'b1, cord(10'd5, 9'd479), "cord_x5_ymax");
    send(OP_ACT,  8'd3, 4'd4, 1'b1, 14'h3FFE, 32'd0, 5'd0, 1'b0, 32'd0, "addx_m2");
    send(OP_RD,   8'd3, 4'd0, 1'b1, 14'd0,    32'd0, 5'd9, 1'b1, ent(1'b0, 4'd4, 8'h00, 10'd3, 9'd479), "rd3_final");

    // Visibility via the register operand path, LD via reg_data, inert action.
    send(OP_ACT, 8'd9, 4'd0, 1'b0, 14'h3FFF, 32'd0,        5'd0,  1'b0, 32'd0, "show9");
    send(OP_RD,  8'd9, 4'd0, 1'b1, 14'd0,    32'd0,        5'd10, 1'b1, 32'h8000_0000, "rd9_show");
    send(OP_ACT, 8'd9, 4'd1, 1'b1, 14'd0,    32'd0,        5'd0,  1'b0, 32'd0, "hide9");
    send(OP_RD,  8'd9, 4'd0, 1'b1, 14'd0,    32'd0,        5'd11, 1'b1, 32'h0800_0000, "rd9_hide");
    send(OP_LD,  8'd9, 4'd0, 1'b0, 14'h3FFF, 32'hFFFF_C0A5, 5'd0, 1'b0, 32'd0, "ld9_reg");
    send(OP_RD,  8'd9, 4'd0, 1'b1, 14'd0,    32'd0,        5'd12, 1'b1, ent(1'b0, 4'd1, 8'hA5, 10'd0, 9'd0), "rd9_ld");
    send(OP_ACT, 8'd9, 4'd7, 1'b1, 14'h1234, 32'd0,        5'd0,  1'b0, 32'd0, "act7_9");
    send(OP_RD,  8'd9, 4'd0, 1'b1, 14'd0,    32'd0,        5'd31, 1'b1, ent(1'b0, 4'd7, 8'hA5, 10'd0, 9'd0), "rd9_act7");

    // Last table entry.
    send(OP_RD, 8'd255, 4'd0, 1'b1, 14'd0,   32'd0, 5'd1, 1'b1, 32'd0, "rd255_clear");
    send(OP_LD, 8'd255, 4'd0, 1'b1, 14'h0FF, 32'd0, 5'd0, 1'b0, 32'd0, "ld255");
    send(OP_RD, 8'd255, 4'd0, 1'b1, 14'd0,   32'd0, 5'd2, 1'b1, ent(1'b0, 4'd0, 8'hFF, 10'd0, 9'd0), "rd255");

    // cmd_valid held high with back-to-back LDs: ready every third cycle.
    while (cmd_ready !== 1'b1) begin @(posedge clk); #1; end
    cmd_valid      = 1'b1;
    cmd_op         = OP_LD;
    sprite_addr    = 8'd20;
    sprite_use_imm = 1'b1;
    sprite_imm     = 14'h011;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("b2b_ready_%0d", i), 32'(cmd_ready), (i % 3 == 0) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    cmd_op = 3'd6;
    check("rsvd_ready_before", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("rsvd_ready_after", 32'(cmd_ready), 32'd1);
    check("rsvd_busy_after", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    send(OP_RD, 8'd20, 4'd0, 1'b1, 14'd0, 32'd0, 5'd14, 1'b1, ent(1'b0, 4'd0, 8'h11, 10'd0, 9'd0), "rd20");

    // Display port collision: old data on the write edge, new data afterwards.
    disp_addr = 8'd30;
    send(OP_LD, 8'd30, 4'd0, 1'b1, 14'h033, 32'd0, 5'd0, 1'b0, 32'd0, "ld30");
    @(posedge clk); #1;
    check("coll_before", disp_data, 32'd0);
    @(posedge clk); #1;
    check("coll_write_edge", disp_data, 32'd0);
    @(posedge clk); #1;
    check("coll_after", disp_data, ent(1'b0, 4'd0, 8'h33, 10'd0, 9'd0));

    // Reset during RD_WAIT aborts the read and reruns the sweep.
    disp_addr = 8'd5;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_disp", disp_data, ent(1'b0, 4'd0, 8'h2A, 10'd0, 9'd0));
    check("pre_rst_rsp_hold", rsp_data, ent(1'b0, 4'd0, 8'h11, 10'd0, 9'd0));
    send(OP_RD, 8'd5, 4'd0, 1'b1, 14'd0, 32'd0, 5'd12, 1'b0, 32'd0, "rd5_abort");
    #2;
    rst = 1'b1;
    #1;
    check("arst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("arst_busy", 32'(busy), 32'd1);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_rsp_data", rsp_data, 32'd0);
    check("arst_rsp_dst", 32'(rsp_dst_reg), 32'd0);
    check("arst_disp_data", disp_data, 32'd0);
    repeat (2) @(posedge clk);
    release_and_clear("clear2");
    disp_sweep("sweep2");
    send(OP_RD, 8'd5, 4'd0, 1'b1, 14'd0, 32'd0, 5'd15, 1'b1, 32'd0, "rd5_after_rst");

    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
